// File: rtl/sliding_window_ctrl.sv
// ---------------------------------------------------------------------------
// sliding_window_ctrl
//
// Purpose:
//   Control sequencer for a streaming KxK sliding-window line buffer fed by a
//   raster frame of ROW_WIDTH x NUM_ROWS pixels. Every accepted pixel pulses
//   shift_en so the external window shifts once. The raster position is
//   tracked, and a window-valid beat carrying the top-left coordinates of the
//   complete in-frame neighbourhood is presented on a valid/ready stream.
//
// Parameters:
//   KERNEL_SIZE  window edge length K (2 <= K <= min(ROW_WIDTH, NUM_ROWS))
//   ROW_WIDTH    pixels per row
//   NUM_ROWS     rows per frame
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous reset, active low
//   in_valid    source offers a pixel this cycle
//   in_sof      marks the offered pixel as the first pixel of a frame
//   in_ready    controller can accept a pixel (output register free/draining)
//   shift_en    in_valid & in_ready, window shifts on this edge
//   out_valid   a complete neighbourhood is held in the window
//   out_ready   downstream consumes the window beat
//   out_col     top-left column of the valid window
//   out_row     top-left row of the valid window
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//   busy        high whenever a frame is in progress
//   sof_err     (optional) sticky flag, a frame was aborted by a mid-frame sof
//
// Optional feature macro: SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
//   When defined, an in_sof accepted mid-frame aborts the frame and restarts
//   at (0,0); sof_err is added and latches until reset. When undefined,
//   mid-frame in_sof is treated as ordinary data.
// ---------------------------------------------------------------------------
module sliding_window_ctrl #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_WIDTH   = 640,
  parameter int NUM_ROWS    = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_sof,
  output logic                          in_ready,
  output logic                          shift_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ROW_WIDTH)-1:0]  out_col,
  output logic [$clog2(NUM_ROWS)-1:0]   out_row,
  output logic                          frame_done,
  output logic                          busy
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
  ,
  output logic                          sof_err
`endif
);

  localparam int COL_W = $clog2(ROW_WIDTH);
  localparam int ROW_W = $clog2(NUM_ROWS);

  localparam logic [COL_W-1:0] LAST_COL       = COL_W'(ROW_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW       = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] K_COL_OFF      = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] K_ROW_OFF      = ROW_W'(KERNEL_SIZE - 1);
  // Last row of the priming phase: leaving it means K-1 full rows are buffered.
  localparam logic [ROW_W-1:0] PRIME_LAST_ROW = ROW_W'(KERNEL_SIZE - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               outValid_q, outValid_d;
  logic [COL_W-1:0]   outCol_q, outCol_d;
  logic [ROW_W-1:0]   outRow_q, outRow_d;
  logic               frameDone_q, frameDone_d;
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
  logic               sofErr_q, sofErr_d;
`endif

  logic accept;

  // A single output register with no skid buffer: a new pixel may only be
  // taken when the register is empty or being drained this very cycle.
  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign shift_en = accept;

  // Next-state logic. Counters move only on accepted in-frame pixels; the
  // window beat is produced from the position of the pixel just accepted,
  // so a completing accept overwrites a beat that is drained in the same
  // cycle and sustains one beat per clock.
  always_comb begin
    logic advance;
    advance     = 1'b0;
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    outValid_d  = outValid_q;
    outCol_d    = outCol_q;
    outRow_d    = outRow_q;
    frameDone_d = 1'b0;
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
    sofErr_d    = sofErr_q;
`endif

    if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          // Pixels without sof while idle still shift the window but are
          // not counted; the sof pixel itself is (0,0).
          if (in_sof) begin
            state_d = PRIME;
            col_d   = COL_W'(1);
            row_d   = '0;
          end
        end
        PRIME, STREAM: begin
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
          if (in_sof) begin
            state_d    = PRIME;
            col_d      = COL_W'(1);
            row_d      = '0;
            outValid_d = 1'b0;
            sofErr_d   = 1'b1;
          end else begin
            advance = 1'b1;
          end
`else
          advance = 1'b1;
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (advance) begin
      // Rows below K-1 never occur in STREAM, so only the column needs testing.
      if (state_q == STREAM && col_q >= K_COL_OFF) begin
        outValid_d = 1'b1;
        outCol_d   = col_q - K_COL_OFF;
        outRow_d   = row_q - K_ROW_OFF;
      end
      if (col_q == LAST_COL) begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          state_d     = IDLE;
          row_d       = '0;
          frameDone_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
          if (state_q == PRIME && row_q == PRIME_LAST_ROW) begin
            state_d = STREAM;
          end
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset; reset also drops any
  // pending window beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      outValid_q  <= 1'b0;
      outCol_q    <= '0;
      outRow_q    <= '0;
      frameDone_q <= 1'b0;
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
      sofErr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      outValid_q  <= outValid_d;
      outCol_q    <= outCol_d;
      outRow_q    <= outRow_d;
      frameDone_q <= frameDone_d;
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
      sofErr_q    <= sofErr_d;
`endif
    end
  end

  assign out_valid  = outValid_q;
  assign out_col    = outCol_q;
  assign out_row    = outRow_q;
  assign frame_done = frameDone_q;
  assign busy       = (state_q != IDLE);
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
  assign sof_err    = sofErr_q;
`endif

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sliding_window_ctrl
//
// Two controller instances: unit 0 (K=3, 5x4 frame) and unit 1 (K=5, 10x5
// frame). A behavioural model predicts every output from the accepted pixel
// index of the frame (row = idx / W, col = idx % W). Outputs are sampled on
// the falling edge; inputs change 1 time unit after the rising edge.
// Optional macro: SLIDING_WINDOW_CTRL_SOF_RESYNC_EN adds the resync scenario.
// ---------------------------------------------------------------------------
module tb_sliding_window_ctrl;

  localparam int K0 = 3, W0 = 5,  H0 = 4;
  localparam int K1 = 5, W1 = 10, H1 = 5;
  localparam int CW0 = $clog2(W0), RW0 = $clog2(H0);
  localparam int CW1 = $clog2(W1), RW1 = $clog2(H1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] inValid = 2'b00;
  logic [1:0] inSof = 2'b00;
  logic [1:0] outReady = 2'b11;

  logic inReady0, shiftEn0, outValid0, frameDone0, busy0;
  logic inReady1, shiftEn1, outValid1, frameDone1, busy1;
  logic [CW0-1:0] outCol0;
  logic [RW0-1:0] outRow0;
  logic [CW1-1:0] outCol1;
  logic [RW1-1:0] outRow1;
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
  logic sofErr0, sofErr1;
`endif

  always #5 clk = ~clk;

  sliding_window_ctrl #(.KERNEL_SIZE(K0), .ROW_WIDTH(W0), .NUM_ROWS(H0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(inValid[0]), .in_sof(inSof[0]),
    .in_ready(inReady0), .shift_en(shiftEn0), .out_valid(outValid0),
    .out_ready(outReady[0]), .out_col(outCol0), .out_row(outRow0),
    .frame_done(frameDone0), .busy(busy0)
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
    , .sof_err(sofErr0)
`endif
  );

  sliding_window_ctrl #(.KERNEL_SIZE(K1), .ROW_WIDTH(W1), .NUM_ROWS(H1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inValid[1]), .in_sof(inSof[1]),
    .in_ready(inReady1), .shift_en(shiftEn1), .out_valid(outValid1),
    .out_ready(outReady[1]), .out_col(outCol1), .out_row(outRow1),
    .frame_done(frameDone1), .busy(busy1)
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
    , .sof_err(sofErr1)
`endif
  );

  // Gather both units' outputs into arrays so one monitor loop covers both.
  logic [1:0] dInReady, dShiftEn, dOutValid, dFrameDone, dBusy;
  logic [31:0] dCol [2];
  logic [31:0] dRow [2];
  assign dInReady   = {inReady1, inReady0};
  assign dShiftEn   = {shiftEn1, shiftEn0};
  assign dOutValid  = {outValid1, outValid0};
  assign dFrameDone = {frameDone1, frameDone0};
  assign dBusy      = {busy1, busy0};
  assign dCol[0] = 32'(outCol0);
  assign dCol[1] = 32'(outCol1);
  assign dRow[0] = 32'(outRow0);
  assign dRow[1] = 32'(outRow1);
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
  logic [1:0] dSofErr;
  assign dSofErr = {sofErr1, sofErr0};
`endif

  // Reference model state: what the registered outputs should be now.
  bit mOutValid [2] = '{default: 1'b0};
  int mOutCol [2] = '{default: 0};
  int mOutRow [2] = '{default: 0};
  bit mFrameDone [2] = '{default: 1'b0};
  bit mInFrame [2] = '{default: 1'b0};
  bit mSofErr [2] = '{default: 1'b0};
  int mPix [2] = '{default: 0};

  int checkCount = 0;
  int failCount = 0;
  int beatCnt [2] = '{default: 0};
  int fdCnt [2] = '{default: 0};
  int qRow [$];
  int qCol [$];

  function automatic int kOf(input int u);
    return (u == 0) ? K0 : K1;
  endfunction
  function automatic int wOf(input int u);
    return (u == 0) ? W0 : W1;
  endfunction
  function automatic int hOf(input int u);
    return (u == 0) ? H0 : H1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Predict the register contents after the coming rising edge from the
  // inputs that are stable now. A window completes at frame pixel idx when
  // both its row and column are at least K-1.
  task automatic modelStep(input int u);
    int k, w, h, r, c;
    bit rdy, acc, newV, drop;
    k = kOf(u); w = wOf(u); h = hOf(u);
    if (!reset) begin
      mOutValid[u] = 0; mOutCol[u] = 0; mOutRow[u] = 0;
      mFrameDone[u] = 0; mInFrame[u] = 0; mSofErr[u] = 0; mPix[u] = 0;
      return;
    end
    rdy = !mOutValid[u] || outReady[u];
    acc = inValid[u] && rdy;
    newV = 0; drop = 0;
    mFrameDone[u] = 0;
    if (acc) begin
      if (!mInFrame[u]) begin
        if (inSof[u]) begin
          mInFrame[u] = 1;
          mPix[u] = 1;
        end
      end
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
      else if (inSof[u]) begin
        mPix[u] = 1;
        mSofErr[u] = 1;
        drop = 1;
      end
`endif
      else begin
        r = mPix[u] / w;
        c = mPix[u] % w;
        if (r >= k - 1 && c >= k - 1) begin
          newV = 1;
          mOutRow[u] = r - (k - 1);
          mOutCol[u] = c - (k - 1);
        end
        if (mPix[u] == w * h - 1) begin
          mFrameDone[u] = 1;
          mInFrame[u] = 0;
          mPix[u] = 0;
        end else begin
          mPix[u]++;
        end
      end
    end
    if (newV) mOutValid[u] = 1;
    else if (drop) mOutValid[u] = 0;
    else if (outReady[u]) mOutValid[u] = 0;
  endtask

  // Falling-edge monitor: compare against the model, tally beats, then
  // advance the model with the inputs that the next rising edge will see.
  always begin
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      bit expReady;
      expReady = !mOutValid[u] || outReady[u];
      checkOutput($sformatf("u%0d.in_ready", u), 32'(dInReady[u]), 32'(expReady));
      checkOutput($sformatf("u%0d.shift_en", u), 32'(dShiftEn[u]), 32'(inValid[u] && expReady));
      checkOutput($sformatf("u%0d.out_valid", u), 32'(dOutValid[u]), 32'(mOutValid[u]));
      checkOutput($sformatf("u%0d.frame_done", u), 32'(dFrameDone[u]), 32'(mFrameDone[u]));
      checkOutput($sformatf("u%0d.busy", u), 32'(dBusy[u]), 32'(mInFrame[u]));
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
      checkOutput($sformatf("u%0d.sof_err", u), 32'(dSofErr[u]), 32'(mSofErr[u]));
`endif
      if (mOutValid[u]) begin
        checkOutput($sformatf("u%0d.out_col", u), dCol[u], mOutCol[u]);
        checkOutput($sformatf("u%0d.out_row", u), dRow[u], mOutRow[u]);
      end
      if (dOutValid[u] === 1'b1 && outReady[u]) begin
        beatCnt[u]++;
        if (u == 0) begin
          qRow.push_back(int'(dRow[0]));
          qCol.push_back(int'(dCol[0]));
        end
      end
      if (dFrameDone[u] === 1'b1) fdCnt[u]++;
    end
    for (int u = 0; u < 2; u++) modelStep(u);
  end

  // One cycle of stimulus for unit u.
  task automatic applyStimulus(input int u, input bit v, input bit s, input bit r);
    @(posedge clk);
    #1;
    inValid[u] = v;
    inSof[u] = s;
    outReady[u] = r;
  endtask

  task automatic clearStats();
    beatCnt = '{default: 0};
    fdCnt = '{default: 0};
    qRow.delete();
    qCol.delete();
  endtask

  task automatic sendFrame0();
    for (int i = 0; i < W0 * H0; i++) applyStimulus(0, 1'b1, (i == 0), 1'b1);
    repeat (4) applyStimulus(0, 1'b0, 1'b0, 1'b1);
  endtask

  // Unit 0 windows in raster order for a full 5x4 frame with K=3.
  task automatic checkTable(input string tag);
    int expRow [6] = '{0, 0, 0, 1, 1, 1};
    int expCol [6] = '{0, 1, 2, 0, 1, 2};
    checkOutput({tag, ".beats"}, qRow.size(), 6);
    checkOutput({tag, ".frame_done_count"}, fdCnt[0], 1);
    for (int i = 0; i < 6 && i < qRow.size(); i++) begin
      checkOutput($sformatf("%s.row%0d", tag, i), qRow[i], expRow[i]);
      checkOutput($sformatf("%s.col%0d", tag, i), qCol[i], expCol[i]);
    end
  endtask

  initial begin
    int resetAt [2] = '{9, 14};
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.out_valid", 32'(outValid0), 0);
    checkOutput("rst.out_col", 32'(outCol0), 0);
    checkOutput("rst.out_row", 32'(outRow0), 0);
    checkOutput("rst.in_ready", 32'(inReady0), 1);
    reset = 1'b1;

    // Basic frame, continuous flow.
    clearStats();
    sendFrame0();
    checkTable("t1");

    // Non-sof pixels while idle are discarded.
    clearStats();
    repeat (3) applyStimulus(0, 1'b1, 1'b0, 1'b1);
    sendFrame0();
    checkTable("t2");

    // Backpressure on the first window for 4 cycles.
    clearStats();
    for (int c = 0; c < 30; c++) applyStimulus(0, 1'b1, (c == 0), !(c >= 13 && c < 17));
    repeat (4) applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkTable("t3");

    // Reset mid-frame, then a clean frame.
    foreach (resetAt[j]) begin
      for (int i = 0; i < resetAt[j]; i++) applyStimulus(0, 1'b1, (i == 0), 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      inValid[0] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t4.busy", 32'(busy0), 0);
      checkOutput("t4.out_valid", 32'(outValid0), 0);
      reset = 1'b1;
      clearStats();
      sendFrame0();
      checkTable("t4");
    end

    // Unit 1: random input gaps, then random input gaps and backpressure.
    for (int f = 0; f < 2; f++) begin
      clearStats();
      cyc = 0;
      while (fdCnt[1] == 0 && cyc < 600) begin
        bit s;
        if (!mInFrame[1]) s = 1'b1;
`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
        else s = 1'b0;
`else
        else s = 1'($urandom_range(0, 1));
`endif
        applyStimulus(1, 1'($urandom_range(0, 1)), s,
                      (f == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        cyc++;
      end
      repeat (3) applyStimulus(1, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("t5.f%0d.frame_done_count", f), fdCnt[1], 1);
      checkOutput($sformatf("t5.f%0d.beats", f), beatCnt[1], 6);
    end

`ifdef SLIDING_WINDOW_CTRL_SOF_RESYNC_EN
    // Mid-frame sof at pixel 8 aborts; following 20 pixels form a frame.
    clearStats();
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, (i == 0), 1'b1);
    sendFrame0();
    checkOutput("t6.sof_err", 32'(sofErr0), 1);
    checkTable("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
